// File: rtl/psum_requant_ctrl_if.sv
// Psum input and ofmap output valid/ready links of the requantization controller.
// master drives psums and consumes ofmap results; slave is the controller itself.
interface psum_requant_ctrl_if #(
  parameter int PSUM_W = 21,
  parameter int OUT_W  = 8
);
  logic signed [PSUM_W-1:0] psum_in;
  logic                     psum_in_valid;
  logic                     psum_in_ready;
  logic signed [OUT_W-1:0]  ofmap_out;
  logic                     ofmap_out_valid;
  logic                     ofmap_out_ready;

  modport master (
    output psum_in, psum_in_valid, ofmap_out_ready,
    input  psum_in_ready, ofmap_out, ofmap_out_valid
  );

  modport slave (
    input  psum_in, psum_in_valid, ofmap_out_ready,
    output psum_in_ready, ofmap_out, ofmap_out_valid
  );
endinterface

// File: rtl/psum_requant_ctrl.sv
// Accumulates acc_len psum beats per pixel, requantizes by arithmetic shift, emits 8-bit ofmap values.
// Latency: ofmap valid two cycles after the beat of the last psum; PSUM_REQ_SAT_EN selects saturation.
// Backpressure: psum_in_ready only in ACCUM; the result holds in OUT until ofmap_out_ready.
module psum_requant_ctrl #(
  parameter int PSUM_W  = 21,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int MAX_ACC = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [2:0]          cfg_acc_len,
  input  logic [3:0]          cfg_shift,
  input  logic [15:0]         cfg_num_out,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  psum_requant_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, QUANT, OUT} state_t;

  state_t                   state;
  state_t                   nxt_state;
  logic [2:0]               acc_len_q;
  logic [3:0]               shift_q;
  logic [15:0]              num_out_q;
  logic [15:0]              out_cnt;
  logic [2:0]               beat_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [OUT_W-1:0]  ofmap_q;
  logic signed [OUT_W-1:0]  q_out;
  logic                     cfg_legal;
  logic                     in_hs;
  logic                     out_hs;
  logic                     last_beat;
  logic                     last_out;

  assign cfg_legal = (cfg_acc_len != 3'd0) && (cfg_acc_len <= 3'(MAX_ACC)) &&
                     (cfg_num_out != 16'd0);
  assign in_hs     = (state == ACCUM) && bus.psum_in_valid;
  assign out_hs    = (state == OUT) && bus.ofmap_out_ready;
  assign last_beat = (beat_cnt == acc_len_q - 3'd1);
  assign last_out  = (out_cnt == num_out_q - 16'd1);
  assign psum_ext  = {{(ACC_W-PSUM_W){bus.psum_in[PSUM_W-1]}}, bus.psum_in};

  assign busy              = (state != IDLE);
  assign bus.psum_in_ready = (state == ACCUM);
  assign bus.ofmap_out_valid = (state == OUT);
  assign bus.ofmap_out     = ofmap_q;

`ifdef PSUM_REQ_SAT_EN
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = -Q_MAX - ACC_W'(1);
  logic signed [ACC_W-1:0] q;
  assign q = acc >>> shift_q;
  always_comb begin
    q_out = q[OUT_W-1:0];
    if (q > Q_MAX)      q_out = Q_MAX[OUT_W-1:0];
    else if (q < Q_MIN) q_out = Q_MIN[OUT_W-1:0];
  end
`else
  // Plain truncation: values outside the 8-bit range wrap modulo 256.
  assign q_out = OUT_W'(acc >>> shift_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (cfg_start && cfg_legal) nxt_state = ACCUM;
      ACCUM:   if (in_hs && last_beat) nxt_state = QUANT;
      QUANT:   nxt_state = OUT;
      OUT:     if (out_hs) nxt_state = last_out ? IDLE : ACCUM;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_len_q <= '0;
      shift_q   <= '0;
      num_out_q <= '0;
      out_cnt   <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      ofmap_q   <= '0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if ((state == IDLE) && cfg_start) begin
        if (cfg_legal) begin
          acc_len_q <= cfg_acc_len;
          shift_q   <= cfg_shift;
          num_out_q <= cfg_num_out;
          out_cnt   <= '0;
          beat_cnt  <= '0;
        end else begin
          err_cfg <= 1'b1;
        end
      end
      if (in_hs) begin
        acc      <= (beat_cnt == 3'd0) ? psum_ext : acc + psum_ext;
        beat_cnt <= last_beat ? 3'd0 : beat_cnt + 3'd1;
      end
      if (state == QUANT) ofmap_q <= q_out;
      if (out_hs) begin
        out_cnt <= out_cnt + 16'd1;
        if (last_out) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_requant_ctrl.sv
// Directed-vector bench for psum_requant_ctrl; build with +define+PSUM_REQ_SAT_EN for the saturating variant.
module tb_psum_requant_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [2:0]  cfg_acc_len;
  logic [3:0]  cfg_shift;
  logic [15:0] cfg_num_out;
  logic        busy, done, err_cfg;
  int          n_chk = 0;
  int          n_fail = 0;

  psum_requant_ctrl_if bus ();

  psum_requant_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_acc_len (cfg_acc_len),
    .cfg_shift   (cfg_shift),
    .cfg_num_out (cfg_num_out),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_cfg(input logic [2:0] len, input logic [3:0] sh, input logic [15:0] num);
    cfg_start = 1'b1; cfg_acc_len = len; cfg_shift = sh; cfg_num_out = num;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send(input int v);
    int n = 0;
    bus.psum_in = 21'(v);
    bus.psum_in_valid = 1'b1;
    while (!bus.psum_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", {31'd0, bus.psum_in_ready}, 32'd1);
    @(negedge clk);
    bus.psum_in_valid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [7:0] exp, input logic exp_done);
    int n = 0;
    while (!bus.ofmap_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, {31'd0, bus.ofmap_out_valid}, 32'd1);
    chk(tag, {24'd0, bus.ofmap_out}, {24'd0, exp});
    bus.ofmap_out_ready = 1'b1;
    @(negedge clk);
    bus.ofmap_out_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_vdrop"}, {31'd0, bus.ofmap_out_valid}, 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
`ifdef PSUM_REQ_SAT_EN
    logic [7:0] exp_pos300 = 8'h7F, exp_neg300 = 8'h80, exp_max6 = 8'h7F;
`else
    logic [7:0] exp_pos300 = 8'h2C, exp_neg300 = 8'hD4, exp_max6 = 8'hBF;
`endif
    rst_n = 1'b0; cfg_start = 1'b0; cfg_acc_len = '0; cfg_shift = '0; cfg_num_out = '0;
    bus.psum_in = '0; bus.psum_in_valid = 1'b0; bus.ofmap_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err_cfg}, 32'd0);
    chk("rst_ovld", {31'd0, bus.ofmap_out_valid}, 32'd0);
    chk("rst_odat", {24'd0, bus.ofmap_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE never accepts psums
    bus.psum_in_valid = 1'b1; bus.psum_in = 21'd99;
    @(negedge clk);
    chk("idle_rdy0", {31'd0, bus.psum_in_ready}, 32'd0);
    @(negedge clk);
    chk("idle_rdy1", {31'd0, bus.psum_in_ready}, 32'd0);
    bus.psum_in_valid = 1'b0;

    // Basic: (10+20+30)>>>2 = 15, valid exactly two cycles after the last beat
    start_cfg(3'd3, 4'd2, 16'd1);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    send(10); send(20); send(30);
    chk("basic_quant_vld", {31'd0, bus.ofmap_out_valid}, 32'd0);
    chk("basic_quant_rdy", {31'd0, bus.psum_in_ready}, 32'd0);
    @(negedge clk);
    chk("basic_lat_vld", {31'd0, bus.ofmap_out_valid}, 32'd1);
    get_out("basic", 8'd15, 1'b1);
    chk("basic_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("basic_done_pulse", {31'd0, done}, 32'd0);

    // Negative: (-100-60)>>>4 = -10
    start_cfg(3'd2, 4'd4, 16'd1);
    send(-100); send(-60);
    get_out("neg", 8'hF6, 1'b1);

    // Overflow, acc_len=1 straight to QUANT
    start_cfg(3'd1, 4'd0, 16'd2);
    send(300);
    get_out("ovf_pos", exp_pos300, 1'b0);
    send(-300);
    get_out("ovf_neg", exp_neg300, 1'b1);

    // Back-pressure, shift=1, 4 outputs
    start_cfg(3'd2, 4'd1, 16'd4);
    send(7); send(9);
    @(negedge clk);
    held = bus.ofmap_out;
    chk("bp_first", {24'd0, held}, 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld_hold", {31'd0, bus.ofmap_out_valid}, 32'd1);
      chk("bp_dat_hold", {24'd0, bus.ofmap_out}, {24'd0, held});
      chk("bp_in_rdy", {31'd0, bus.psum_in_ready}, 32'd0);
    end
    get_out("bp_o0", 8'd8, 1'b0);
    send(-5); send(-6);
    get_out("bp_o1", 8'hFA, 1'b0);
    send(100); send(54);
    get_out("bp_o2", 8'h4D, 1'b0);
    send(-1); send(0);
    get_out("bp_o3", 8'hFF, 1'b1);
    @(negedge clk);
    chk("bp_single_done", {31'd0, done}, 32'd0);

    // Max acc_len with full-scale psums; cfg_start mid-ACCUM ignored
    start_cfg(3'd6, 4'd15, 16'd1);
    send(1048575);
    start_cfg(3'd1, 4'd0, 16'd1);
    chk("accum_start_err", {31'd0, err_cfg}, 32'd0);
    chk("accum_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) send(1048575);
    get_out("max6", exp_max6, 1'b1);

    // Illegal configurations
    for (int i = 0; i < 3; i++) begin
      logic [2:0] l;
      logic [15:0] m;
      l = (i == 0) ? 3'd7 : (i == 1) ? 3'd0 : 3'd3;
      m = (i == 2) ? 16'd0 : 16'd1;
      start_cfg(l, 4'd0, m);
      chk($sformatf("cfg_err%0d", i), {31'd0, err_cfg}, 32'd1);
      chk($sformatf("cfg_busy%0d", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("cfg_err_pulse%0d", i), {31'd0, err_cfg}, 32'd0);
    end

    // Reset mid-ACCUM discards work
    start_cfg(3'd3, 4'd0, 16'd1);
    send(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, bus.psum_in_ready}, 32'd0);
    chk("mid_rst_odat", {24'd0, bus.ofmap_out}, 32'd0);
    chk("mid_rst_ovld", {31'd0, bus.ofmap_out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_cfg(3'd1, 4'd0, 16'd1);
    send(5);
    get_out("post_rst", 8'd5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
